// File: rtl/snake_mem_arbiter.sv
// snake_mem_arbiter: single-port snake memory arbiter (VGA priority, game starvation guard, game lock); SNAKE_ARB_STATS_EN adds stat counters
module snake_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15,
  parameter int LOCK_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  input  logic              g_lock,
  output logic              g_gnt,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] g_rdata,
  output logic              lock_abort,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_rvalid,
  output logic [DATA_W-1:0] v_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_conflicts,
  output logic [7:0]        stat_aborts
);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  typedef enum logic {NORMAL, LOCK} state_e;
  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          block_q, block_d;
  logic          g_rv_q, v_rv_q;
  logic          starve_max;
  assign starve_max = starve_q == SW'(MAX_WAIT);
  // grant decision, lock tracking and starvation bookkeeping; grants forced low in reset
  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    g_gnt      = 1'b0;
    v_gnt      = 1'b0;
    lock_abort = 1'b0;
    if (state_q == LOCK) begin
      g_gnt      = rst_n & g_req;
      lock_abort = g_lock & (lock_q == LW'(LOCK_MAX));
      lock_d     = lock_q + LW'(1);
      state_d    = (!g_lock || lock_abort) ? NORMAL : LOCK;
    end else begin
      v_gnt = rst_n & v_req & !(g_req & starve_max);
      g_gnt = rst_n & g_req & !v_gnt;
      if (g_gnt && g_lock && !block_q) begin
        state_d = LOCK;
        lock_d  = LW'(1);
      end
    end
    block_d  = lock_abort | (block_q & g_lock);
    starve_d = (g_req & !g_gnt) ? (starve_max ? starve_q : starve_q + SW'(1)) : '0;
  end
  assign mem_en     = g_gnt | v_gnt;
  assign mem_we     = g_gnt & g_we;
  assign mem_addr   = g_gnt ? g_addr : v_gnt ? v_addr : '0;
  assign mem_wdata  = g_gnt ? g_wdata : '0;
  assign g_rvalid   = g_rv_q;
  assign v_rvalid   = v_rv_q;
  assign g_rdata    = g_rv_q ? mem_rdata : '0;
  assign v_rdata    = v_rv_q ? mem_rdata : '0;
  // state register; read-return owner flags mark the cycle after a granted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      lock_q   <= '0;
      block_q  <= 1'b0;
      g_rv_q   <= 1'b0;
      v_rv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      block_q  <= block_d;
      g_rv_q   <= g_gnt & !g_we;
      v_rv_q   <= v_gnt;
    end
  end
`ifdef SNAKE_ARB_STATS_EN
  logic [15:0] conf_q;
  logic [7:0]  ab_q;
  // saturating conflict and forced-release counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_q <= '0;
      ab_q   <= '0;
    end else begin
      if (g_req && v_req && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
      if (lock_abort && ab_q != 8'hFF) ab_q <= ab_q + 8'd1;
    end
  end
  assign stat_conflicts = conf_q;
  assign stat_aborts    = ab_q;
`else
  assign stat_conflicts = '0;
  assign stat_aborts    = '0;
`endif
endmodule

// File: doc/snake_mem_arbiter.md
Name: snake_mem_arbiter

Overview:
- Arbitrates the single-port snake memory between two requesters.
- Requester G is the game logic: read/write, with an optional lock for atomic per-tick updates.
- Requester V is the VGA renderer: read-only.
- Sits between game_logic, the VGA controller and snake_memory, and owns the memory command bus.
- VGA has priority by default; a starvation counter guarantees the game forward progress.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width
- MAX_WAIT, 15, consecutive denied game cycles before game wins one arbitration
- LOCK_MAX, 255, maximum cycles a game lock may be held before forced release

Ports:
- clk  in  1  system clock (global game clock)
- rst_n  in  1  asynchronous active-low reset
- g_req  in  1  game request; held with g_we/g_addr/g_wdata until g_gnt
- g_we  in  1  1 = write, 0 = read
- g_addr  in  ADDR_W  game address
- g_wdata  in  DATA_W  game write data
- g_lock  in  1  game requests exclusive ownership while high
- g_gnt  out  1  game access accepted this cycle
- g_rvalid  out  1  game read data valid
- g_rdata  out  DATA_W  game read data
- lock_abort  out  1  one-cycle pulse when a lock is force-released
- v_req  in  1  VGA read request; held with v_addr until v_gnt
- v_addr  in  ADDR_W  VGA address
- v_gnt  out  1  VGA access accepted this cycle
- v_rvalid  out  1  VGA read data valid
- v_rdata  out  DATA_W  VGA read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0
- stat_conflicts  out  16  conflict counter (see Optional Feature)
- stat_aborts  out  8  lock-abort counter (see Optional Feature)

Behaviour:
- Reset values:
  - All registered state is cleared asynchronously by rst_n=0: state=NORMAL, starve_cnt=0, lock_cnt=0, rvalid owner flags=0, stats=0.
  - Every output is 0 while in reset. Reads in flight at reset are discarded; no rvalid is issued after reset release.
- Grant timing:
  - Grants and mem_* outputs are combinational from req and state, in the same cycle. At most one of g_gnt/v_gnt is high.
  - mem_en = g_gnt | v_gnt. mem_we = g_gnt & g_we. mem_addr/mem_wdata are muxed from the granted requester; mem_wdata = 0 for VGA.
- Read return:
  - Read latency is 1 cycle: x_rvalid is registered high the cycle after a granted read.
  - x_rdata = mem_rdata when x_rvalid is high, otherwise 0.
  - Writes produce no rvalid.
- State NORMAL:
  - If v_req and not (g_req and starve_cnt == MAX_WAIT): grant V.
  - Else if g_req: grant G.
- Starvation counter:
  - starve_cnt increments when g_req & !g_gnt, saturating at MAX_WAIT.
  - Clears to 0 on g_gnt, or when g_req is low.
- Entering and holding LOCK:
  - NORMAL -> LOCK when g_gnt & g_lock. lock_cnt loads 1.
  - In LOCK, v_gnt = 0 and G is granted whenever g_req is high.
  - lock_cnt increments every LOCK cycle.
- Leaving LOCK:
  - LOCK -> NORMAL in the cycle after g_lock is sampled low.
  - Forced exit when lock_cnt == LOCK_MAX and g_lock is still high: return to NORMAL and pulse lock_abort for 1 cycle.
  - After a forced exit, G cannot re-enter LOCK until g_lock has been observed low for at least 1 cycle.
- Simultaneous events:
  - g_req & v_req with starve_cnt < MAX_WAIT: V wins.
  - At starve_cnt == MAX_WAIT: G wins exactly once, then the counter clears.
- Handshake rules:
  - A requester that drops req before its grant is legal; the request is simply withdrawn.
  - Changing addr while req is high and not granted is legal; the value in the grant cycle is used.

Optional Feature:
- Macro: SNAKE_ARB_STATS_EN.
- Defined:
  - stat_conflicts counts cycles with g_req & v_req, saturating at 16'hFFFF.
  - stat_aborts counts lock_abort pulses, saturating at 8'hFF.
  - Both are cleared only by reset.
- Undefined: both ports are tied to 0 and the counter logic is absent.
- Arbitration behaviour is identical either way.

Test Plan:
- Reset, then one isolated G write (addr 0x10, data 0x1234) followed by a G read of 0x10 -> g_gnt=1 same cycle each; g_rvalid=1 one cycle after the read with g_rdata=0x1234; v_* all 0.
- v_req and g_req both held high continuously, MAX_WAIT=15 -> v_gnt for 15 cycles, g_gnt in cycle 16, V again in cycle 17; stat_conflicts=16 after 16 cycles (with macro).
- G granted with g_lock=1 for 5 cycles while v_req=1 -> v_gnt=0 throughout; after g_lock drops, V is granted the next cycle.
- g_lock held high with LOCK_MAX=255 -> lock_abort pulses once at lock cycle 255, V granted next; G is not re-locked until g_lock toggles low.
- rst_n asserted the cycle after a granted V read -> v_rvalid stays 0, all outputs 0, starve_cnt and stats cleared.
- Build without SNAKE_ARB_STATS_EN, rerun scenario 2 -> identical grant sequence; stat_conflicts=0.
